bwt: RTL and testbench
======================

Name: bwt

Overview:
- Burrows-Wheeler Transform engine for byte strings up to 1023 characters.
- Load phase: the host writes characters one per clock into an internal 1024x8 input memory.
- Dropping `en` starts the transform: all cyclic rotations are sorted, the last column is stored, and `done_flag` is raised.
- Host then reads the transformed string byte-by-byte through the same address port; standalone accelerator block.

Parameters:
- None. Fixed: data width 8, address width 10, memory depth 1024, max length 1023.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `en`  in  1  1 = load phase; 1->0 transition starts compute
- `adr`  in  10  write address (load phase) / read address (done phase)
- `in_string`  in  8  character written at `adr` while `en`=1
- `length`  in  10  number of valid characters, sampled at compute start
- `outstring`  out  8  transformed character at `adr` (valid when `done_flag`=1)
- `tempo`  out  11  progress count of rotations ranked so far
- `indo`  out  10  primary index: sorted position of the original, unrotated string
- `done_flag`  out  1  transform complete, outputs valid

Behaviour:
- States: LOAD, COMPUTE, DONE. Reset -> LOAD.
- Reset values: `done_flag`=0, `tempo`=0, `indo`=0, `outstring`=0. Memory contents are not cleared.
- LOAD:
  - Each clk with `en`=1: `inmem[adr] <= in_string`.
  - Compute starts only on an observed `en` 1->0 transition (registered `en_d`). `en` held 0 from reset never starts compute.
- String order (byte-reversed addressing):
  - String position p (0 = first character) lives at address `length-1-p`, so address 0 holds the last character.
  - Output position p is read at address `length-1-p`.
- COMPUTE:
  - Registered length L = `length`.
  - Rotation r = S[r..L-1] followed by S[0..r-1], for r = 0..L-1.
  - Rotations sort ascending by unsigned byte compare, lexicographic over L bytes.
  - Equal rotations (periodic strings) are ordered by ascending r (stable).
  - Output position k = last character of the k-th sorted rotation, i.e. S[(r_k+L-1) mod L].
  - `indo` = k where r_k = 0.
  - Implementation: rank-counting is acceptable. rank(r) = number of rotations strictly less than r, plus equal rotations with smaller start index. Results are written into an internal output memory.
  - `tempo` increments by 1 per rotation ranked; equals L at completion.
  - Latency is not fixed (O(L^3) cycles acceptable); `done_flag` is the sole completion indication.
  - Writes are ignored during COMPUTE.
- DONE:
  - `done_flag`=1.
  - `outstring` = `outmem[adr]`, combinational read, updates in the same cycle `adr` changes.
  - Stays in DONE until `en`=1, then -> LOAD with `done_flag` cleared the next cycle and that cycle's write performed.
- `outstring`=0 whenever `done_flag`=0.
- `adr` >= L in DONE: `outstring`=0.
- L=0: COMPUTE finishes immediately; `done_flag`=1, `indo`=0, `tempo`=0.
- L=1: output equals input, `indo`=0.
- `en` rising during COMPUTE: abort, -> LOAD, `tempo` cleared, no `done_flag`.
- `rst` mid-operation: immediate return to LOAD with reset values on the next clk.

Optional Feature:
- Macro `BWT_TEMPO_EN`.
- Defined: `tempo` reports progress as specified.
- Undefined: `tempo` is tied to 0 and its counter logic is removed; all other behaviour is unchanged.

Test Plan:
- "banana": load address 0..5 = "ananab", L=6, drop `en` -> `done_flag`; addresses 5..0 read "nnbaaa"; `indo`=3; `tempo`=6.
- "abc": load "cba" at address 0..2, L=3 -> reading addresses 2..0 gives "cab"; `indo`=0.
- "aaaa": L=4 -> output "aaaa", `indo`=0 (stable tie rule).
- L=1 "x" -> output "x", `indo`=0; L=0 -> `done_flag` shortly after `en` drop, `indo`=0.
- Abort/reset: raise `en` mid-compute -> `done_flag` stays 0, `tempo`=0; reload "banana" and recompute -> correct result. Repeat with `rst` pulse mid-compute -> all outputs 0, no compute without a new `en` 1->0.
- After DONE: raise `en` -> `done_flag`=0 and `outstring`=0 next cycle; new load and compute produce the fresh result.

Source files
------------

// File: rtl/bwt.sv
// bwt: Burrows-Wheeler Transform engine, rank-counting over cyclic rotations.
// Build option: define BWT_TEMPO_EN to enable the tempo progress counter.
module bwt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  adr,
    input  logic [7:0]  in_string,
    input  logic [9:0]  length,
    output logic [7:0]  outstring,
    output logic [10:0] tempo,
    output logic [9:0]  indo,
    output logic        done_flag
);

    typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

    state_t state, state_n;

    logic [7:0] inmem  [1024];
    logic [7:0] outmem [1024];

    logic       en_d;
    logic [9:0] len_q;
    logic [9:0] r, j, i;
    logic [9:0] pj, pr;
    logic [9:0] rank, rank_n;
    logic [9:0] last_adr;
    logic [7:0] ca, cb, clast;
    logic       start, last, conclude, inc;
    logic       row_done, all_done, step;

    // String position p lives at address len_q-1-p.
    always_comb begin
        last_adr = (r == 10'd0) ? 10'd0 : len_q - r;
        ca       = inmem[len_q - 10'd1 - pj];
        cb       = inmem[len_q - 10'd1 - pr];
        clast    = inmem[last_adr];
        start    = en_d && !en;
        last     = (i == len_q - 10'd1);
        conclude = (j == r) || (ca != cb) || last;
        inc      = (j != r) &&
                   ((ca < cb) || ((ca == cb) && last && (j < r)));
        rank_n   = rank + {9'd0, inc};
        row_done = conclude && (j == len_q - 10'd1);
        all_done = row_done && (r == len_q - 10'd1);
        step     = (state == COMPUTE) && !en && (len_q != 10'd0);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            LOAD: begin
                if (start)
                    state_n = COMPUTE;
            end
            COMPUTE: begin
                if (en)
                    state_n = LOAD;
                else if ((len_q == 10'd0) || all_done)
                    state_n = DONE;
            end
            DONE: begin
                if (en)
                    state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_n;
    end

    // One byte pair compared per cycle; rotation j vs rotation r.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d  <= 1'b0;
            len_q <= 10'd0;
            r     <= 10'd0;
            j     <= 10'd0;
            i     <= 10'd0;
            pj    <= 10'd0;
            pr    <= 10'd0;
            rank  <= 10'd0;
            indo  <= 10'd0;
        end else begin
            en_d <= en;
            if ((state == LOAD) && start) begin
                len_q <= length;
                r     <= 10'd0;
                j     <= 10'd0;
                i     <= 10'd0;
                pj    <= 10'd0;
                pr    <= 10'd0;
                rank  <= 10'd0;
                indo  <= 10'd0;
            end else if (step) begin
                if (!conclude) begin
                    i  <= i + 10'd1;
                    pj <= (pj == len_q - 10'd1) ? 10'd0 : pj + 10'd1;
                    pr <= (pr == len_q - 10'd1) ? 10'd0 : pr + 10'd1;
                end else if (!row_done) begin
                    i    <= 10'd0;
                    j    <= j + 10'd1;
                    pj   <= j + 10'd1;
                    pr   <= r;
                    rank <= rank_n;
                end else begin
                    i    <= 10'd0;
                    j    <= 10'd0;
                    pj   <= 10'd0;
                    r    <= r + 10'd1;
                    pr   <= r + 10'd1;
                    rank <= 10'd0;
                    if (r == 10'd0)
                        indo <= rank_n;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && (state != COMPUTE))
            inmem[adr] <= in_string;
    end

    always_ff @(posedge clk) begin
        if (!rst && step && row_done)
            outmem[len_q - 10'd1 - rank_n] <= clast;
    end

`ifdef BWT_TEMPO_EN
    always_ff @(posedge clk) begin
        if (rst)
            tempo <= 11'd0;
        else if ((state == LOAD) && start)
            tempo <= 11'd0;
        else if ((state == COMPUTE) && en)
            tempo <= 11'd0;
        else if (step && row_done)
            tempo <= tempo + 11'd1;
    end
`else
    assign tempo = 11'd0;
`endif

    assign done_flag = (state == DONE);
    assign outstring = ((state == DONE) && (adr < len_q)) ? outmem[adr] : 8'd0;

endmodule

// File: tb/tb_bwt.sv
// tb_bwt: randomized and directed checks of bwt against a
// string-sorting reference model.
module tb_bwt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [9:0]  adr;
    logic [7:0]  in_string;
    logic [9:0]  length;
    logic [7:0]  outstring;
    logic [10:0] tempo;
    logic [9:0]  indo;
    logic        done_flag;

    int vectors = 0;
    int errors  = 0;

    bwt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .adr       (adr),
        .in_string (in_string),
        .length    (length),
        .outstring (outstring),
        .tempo     (tempo),
        .indo      (indo),
        .done_flag (done_flag)
    );

    always #5 clk = ~clk;

    // Stable insertion sort of explicit rotation strings.
    function automatic void ref_bwt(input string s, output string o,
                                    output int pidx);
        int n;
        int k;
        int p;
        string rot[$];
        int ord[$];
        n = s.len();
        o = "";
        pidx = 0;
        for (int r = 0; r < n; r++)
            rot.push_back({s.substr(r, n - 1), s.substr(0, r - 1)});
        for (int r = 0; r < n; r++) begin
            k = ord.size();
            ord.push_back(r);
            while (k > 0 && rot[ord[k-1]] > rot[r]) begin
                ord[k] = ord[k-1];
                k--;
            end
            ord[k] = r;
        end
        for (int q = 0; q < n; q++) begin
            p = (ord[q] + n - 1) % n;
            o = {o, s.substr(p, p)};
            if (ord[q] == 0)
                pidx = q;
        end
    endfunction

    function automatic string rand_str(input int n);
        string s;
        s = "";
        for (int q = 0; q < n; q++)
            s = $sformatf("%s%c", s, 8'(97 + $urandom_range(0, 2)));
        return s;
    endfunction

    task automatic load_str(input string s);
        int n;
        n = s.len();
        if (n == 0) begin
            @(negedge clk);
            en = 1'b1;
            adr = 10'h3ff;
            in_string = 8'h00;
        end
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            en = 1'b1;
            adr = 10'(n - 1 - p);
            in_string = s[p];
        end
        @(negedge clk);
        en = 1'b0;
        length = 10'(n);
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done_flag && c < 20000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (done_flag !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done_flag=%b after %0d cycles, want 1",
                     name, done_flag, c);
        end
    endtask

    task automatic check_result(input string name, input string s);
        string o;
        int pidx;
        int n;
        logic [10:0] exp_t;
        n = s.len();
        ref_bwt(s, o, pidx);
`ifdef BWT_TEMPO_EN
        exp_t = 11'(n);
`else
        exp_t = 11'd0;
`endif
        vectors++;
        if (indo !== 10'(pidx)) begin
            errors++;
            $display("FAIL %s indo: got %0d want %0d", name, indo, pidx);
        end
        vectors++;
        if (tempo !== exp_t) begin
            errors++;
            $display("FAIL %s tempo: got %0d want %0d", name, tempo, exp_t);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            adr = 10'(n - 1 - k);
            #1;
            vectors++;
            if (outstring !== 8'(o[k])) begin
                errors++;
                $display("FAIL %s out[%0d]: got %02h want %02h",
                         name, k, outstring, 8'(o[k]));
            end
        end
        @(negedge clk);
        adr = 10'(n);
        #1;
        vectors++;
        if (outstring !== 8'd0) begin
            errors++;
            $display("FAIL %s out beyond L: got %02h want 00", name, outstring);
        end
    endtask

    task automatic run_case(input string name, input string s);
        load_str(s);
        wait_done(name);
        check_result(name, s);
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (done_flag !== 1'b0 || tempo !== 11'd0 ||
            indo !== 10'd0 || outstring !== 8'd0) begin
            errors++;
            $display("FAIL %s idle: done=%b tempo=%0d indo=%0d out=%02h want 0",
                     name, done_flag, tempo, indo, outstring);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        adr = 10'd0;
        in_string = 8'd0;
        length = 10'd5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        repeat (20) @(negedge clk);
        vectors++;
        if (done_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: done_flag=%b want 0", done_flag);
        end
    endtask

    task automatic test_directed();
        run_case("banana", "banana");
        run_case("abc", "abc");
        run_case("aaaa", "aaaa");
        run_case("abab", "abab");
        run_case("len1", "x");
        run_case("len0", "");
    endtask

    task automatic test_abort();
        load_str("banana");
        repeat (10) @(negedge clk);
        vectors++;
        if (done_flag !== 1'b0) begin
            errors++;
            $display("FAIL abort_running: done_flag=%b want 0", done_flag);
        end
        en = 1'b1;
        adr = 10'h3ff;
        @(negedge clk);
        vectors++;
        if (done_flag !== 1'b0 || tempo !== 11'd0) begin
            errors++;
            $display("FAIL abort_en: done=%b tempo=%0d want 0 0",
                     done_flag, tempo);
        end
        run_case("abort_reload", "banana");

        load_str("banana");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("abort_rst");
        repeat (60) @(negedge clk);
        vectors++;
        if (done_flag !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_restart: done_flag=%b want 0", done_flag);
        end
        run_case("rst_reload", "banana");
    endtask

    task automatic test_back_to_back();
        run_case("pre_reload", "abc");
        @(negedge clk);
        en = 1'b1;
        adr = 10'd0;
        in_string = 8'h7a;
        @(negedge clk);
        adr = 10'd1;
        #1;
        vectors++;
        if (done_flag !== 1'b0 || outstring !== 8'd0) begin
            errors++;
            $display("FAIL done_exit: done=%b out=%02h want 0 00",
                     done_flag, outstring);
        end
        run_case("post_reload", rand_str(7));
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++)
            run_case($sformatf("rand%0d", t), rand_str($urandom_range(2, 14)));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
